uart_loader: RTL
================

UART_LOADER -- requirements
Module: uart_loader

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 139, meaning CLK cycles per UART bit (16 MHz / 115200).
REQ-002 SHALL have parameter MAX_WORDS, default 2048, meaning the program-memory depth in 32-bit words.
REQ-003 SHALL have port CLK  input  1  16 MHz system clock; all state on rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port RX  input  1  UART serial in, 8N1, idle high, asynchronous to CLK.
REQ-006 SHALL have port mem_we  output  1  program-memory write strobe, one cycle per word.
REQ-007 SHALL have port mem_addr  output  11  word address for the write.
REQ-008 SHALL have port mem_wdata  output  32  instruction word for the write.
REQ-009 SHALL have port cpu_hold  output  1  high = CPU held at pc 0, instruction phase 0.
REQ-010 SHALL have port load_done  output  1  high = last frame loaded and checksum passed.
REQ-011 SHALL have port load_err  output  1  high = last frame aborted.

Function
REQ-012 SHALL pass RX through a 2-flop synchronizer before any use.
REQ-013 SHALL treat a synchronized high-to-low edge in RX idle as a candidate start bit.
REQ-014 SHALL recheck RX at CLKS_PER_BIT/2 and return to RX idle without a byte if RX is high there.
REQ-015 SHALL sample 8 data bits, LSB first, each CLKS_PER_BIT cycles after the previous sample point.
REQ-016 SHALL sample the stop bit at its midpoint and produce a 1-cycle byte_valid in the cycle after that sample.
REQ-017 SHALL raise a framing error instead of byte_valid when the stop bit samples 0.
REQ-018 SHALL run a loader FSM with states IDLE, CNT_HI, CNT_LO, DATA, CSUM, DONE, ERR.
REQ-019 SHALL, in IDLE, discard every byte except 0xA5, which moves the FSM to CNT_HI.
REQ-020 SHALL take the word count N as big-endian bytes in CNT_HI then CNT_LO.
REQ-021 SHALL move from CNT_LO to ERR when N == 0 or N > MAX_WORDS, and to DATA otherwise.
REQ-022 SHALL, in DATA, assemble each word big-endian, first byte into bits [31:24].
REQ-023 SHALL clear the word index to 0 on 0xA5 and increment it by 1 after each write, with no wrap.
REQ-024 SHALL assert mem_we for exactly one cycle in the cycle after byte_valid of each word's 4th byte, with mem_addr = word index and mem_wdata = the assembled word.
REQ-025 SHALL hold mem_addr and mem_wdata stable while mem_we is high.
REQ-026 SHALL move to CSUM after the N-th write.
REQ-027 SHALL keep a running XOR of the 4*N data bytes only.
REQ-028 SHALL, in CSUM, move to DONE when the received byte equals the running XOR, and to ERR otherwise.
REQ-029 SHALL, on entry to DONE, drive cpu_hold 0 and load_done 1 in the same cycle.
REQ-030 SHALL, on entry to ERR, drive load_err 1 and keep cpu_hold 1.
REQ-031 SHALL, on a framing error in any state other than IDLE/DONE/ERR, go to ERR; in IDLE/DONE/ERR it has no effect.
REQ-032 SHALL, on 0xA5 received in DONE or ERR, go to CNT_HI, set cpu_hold 1, and clear load_done and load_err.
REQ-033 SHALL discard all other bytes received in DONE or ERR.
REQ-034 SHALL NOT write memory outside DATA, and SHALL NOT write more than N words per frame.

Reset
REQ-035 SHALL, while RST is high, drive mem_we 0, mem_addr 0, mem_wdata 0, cpu_hold 1, load_done 0, load_err 0; FSM in IDLE, UART receiver in RX idle, all counters and the XOR accumulator at 0.
REQ-036 SHALL, when RST is asserted mid-frame or mid-byte, abandon the partial word with no mem_we, and require a fresh 0xA5 after release.

Verification
REQ-037 SHALL cover a good load: bytes A5 00 02 20 00 00 01 11 00 00 00 then checksum 0x30 -> writes (0,0x20000001), (1,0x11000000); then cpu_hold 0 and load_done 1.
REQ-038 SHALL cover a bad checksum: same frame with checksum 0x31 -> both writes occur, then load_err 1 and cpu_hold stays 1.
REQ-039 SHALL cover a bad count: A5 00 00 -> ERR with no write; separately, A5 08 01 -> ERR with no write.
REQ-040 SHALL cover noise rejection: a 0.3-bit low glitch on RX plus bytes 0x00 0xFF in IDLE -> no byte accepted and the FSM stays in IDLE.
REQ-041 SHALL cover reload: after DONE, a new frame A5 00 01 30 00 00 00 30 -> cpu_hold 1 from the 0xA5, one write (0,0x30000000), then DONE again.
REQ-042 SHALL cover reset mid-word: RST pulsed after 2 data bytes -> no mem_we, outputs at reset values, and a full frame sent afterwards loads correctly.

Source files
------------

// File: rtl/uart_loader.sv
// uart_loader: 8N1 UART receiver feeding a framed program loader (A5, count, words, XOR checksum)
// that writes 32-bit instruction words into program memory while the CPU is held.
module uart_loader #(
  parameter int CLKS_PER_BIT = 139,
  parameter int MAX_WORDS = 2048
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        RX,
  output logic        mem_we,
  output logic [10:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [16:0] MAXW = 17'(MAX_WORDS);
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_t;
  typedef enum logic [2:0] {IDLE, CNT_HI, CNT_LO, DATA, CSUM, DONE, ERR} ld_t;
  rx_t rx_state, rx_next;
  ld_t state, ld_next;
  logic rx_s1, rx_s, rx_prev;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] sh, byte_data;
  logic byte_valid, frame_err;
  logic [7:0] n_hi, n_lo, xsum;
  logic [15:0] n_new, idx;
  logic [1:0] bcnt;
  logic [23:0] word;
  logic a5, rearm;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      rx_s1 <= 1'b1;
      rx_s <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1 <= RX;
      rx_s <= rx_s1;
      rx_prev <= rx_s;
    end
  always_ff @(posedge CLK or posedge RST)
    if (RST) rx_state <= R_IDLE;
    else rx_state <= rx_next;
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      R_IDLE: rx_next = (rx_prev && !rx_s) ? R_START : R_IDLE;
      R_START: if (cnt == HALF_END) rx_next = rx_s ? R_IDLE : R_DATA;
      R_DATA: if (cnt == BIT_END && bit_idx == 3'd7) rx_next = R_STOP;
      R_STOP: if (cnt == BIT_END) rx_next = R_IDLE;
      default: rx_next = R_IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      cnt <= '0;
      bit_idx <= '0;
      sh <= '0;
      byte_data <= '0;
      byte_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      cnt <= (rx_state == R_IDLE || rx_next != rx_state || cnt == BIT_END) ? '0 : cnt + 1'b1;
      if (rx_state == R_DATA && cnt == BIT_END) begin
        sh <= {rx_s, sh[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
      byte_valid <= rx_state == R_STOP && cnt == BIT_END && rx_s;
      frame_err <= rx_state == R_STOP && cnt == BIT_END && !rx_s;
      if (rx_state == R_STOP && cnt == BIT_END) byte_data <= sh;
    end
  assign a5 = byte_data == 8'hA5;
  assign rearm = state == IDLE || state == DONE || state == ERR;
  assign n_new = {n_hi, byte_data};
  always_ff @(posedge CLK or posedge RST)
    if (RST) state <= IDLE;
    else state <= ld_next;
  always_comb begin
    ld_next = state;
    if (frame_err && !rearm) ld_next = ERR;
    else if (byte_valid)
      case (state)
        CNT_HI: ld_next = CNT_LO;
        CNT_LO: ld_next = (n_new == 16'd0 || {1'b0, n_new} > MAXW) ? ERR : DATA;
        DATA: if (bcnt == 2'd3 && idx + 16'd1 == {n_hi, n_lo}) ld_next = CSUM;
        CSUM: ld_next = byte_data == xsum ? DONE : ERR;
        default: if (a5) ld_next = CNT_HI;
      endcase
  end
  // word index is post-incremented, so mem_addr captures it before the bump
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      n_hi <= '0;
      n_lo <= '0;
      xsum <= '0;
      idx <= '0;
      bcnt <= '0;
      word <= '0;
    end else begin
      mem_we <= 1'b0;
      if (byte_valid) begin
        if (rearm && a5) begin
          idx <= '0;
          bcnt <= '0;
          xsum <= '0;
        end
        if (state == CNT_HI) n_hi <= byte_data;
        if (state == CNT_LO) n_lo <= byte_data;
        if (state == DATA) begin
          xsum <= xsum ^ byte_data;
          word <= {word[15:0], byte_data};
          bcnt <= bcnt + 2'd1;
          if (bcnt == 2'd3) begin
            mem_we <= 1'b1;
            mem_addr <= idx[10:0];
            mem_wdata <= {word, byte_data};
            idx <= idx + 16'd1;
          end
        end
      end
    end
  assign cpu_hold = state != DONE;
  assign load_done = state == DONE;
  assign load_err = state == ERR;
endmodule
